// File: rtl/trigger_stretcher_pkg.sv
// Shared types and timing helpers for the trigger stretcher (and the button debouncer's timing math).
package trigger_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    GAP  = 2'd2
  } trig_state_t;

  // Ceil of ms * 1e6 / clk_period_ns; a zero period yields 0 so the caller's range check fires.
  function automatic int unsigned ms_to_cycles(input int unsigned ms,
                                               input int unsigned clk_period_ns);
    longint unsigned num;
    longint unsigned per;
    if (clk_period_ns == 0) return 0;
    num = 64'(ms) * 64'd1_000_000;
    per = 64'(clk_period_ns);
    return 32'((num + per - 64'd1) / per);
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/trigger_stretcher.sv
// Stretches single-cycle triggers into fixed-width pulses separated by a fixed low gap.
// Optional pending-trigger queue enabled by defining TRIGGER_STRETCHER_QUEUE_EN.
module trigger_stretcher
  import trigger_pkg::*;
#(
  parameter int unsigned CLK_PERIOD_NS = 10,
  parameter int unsigned PULSE_TIME_MS = 5,
  parameter int unsigned GAP_TIME_MS   = 5,
  parameter int unsigned QUEUE_DEPTH   = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic trig,
  output logic out,
  output logic busy,
  output logic dropped
);

  localparam int unsigned PULSE_CYCLES = ms_to_cycles(PULSE_TIME_MS, CLK_PERIOD_NS);
  localparam int unsigned GAP_CYCLES   = ms_to_cycles(GAP_TIME_MS, CLK_PERIOD_NS);
  localparam int unsigned MAX_CYCLES   = max_u(PULSE_CYCLES, GAP_CYCLES);
  localparam int unsigned CNT_W        = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);

  // Elaboration-time range checks.
  if (PULSE_CYCLES < 1) begin : g_bad_pulse
    $fatal(1, "trigger_stretcher: PULSE_CYCLES must be >= 1");
  end
  if (GAP_CYCLES < 1) begin : g_bad_gap
    $fatal(1, "trigger_stretcher: GAP_CYCLES must be >= 1");
  end
  if (QUEUE_DEPTH < 1) begin : g_bad_depth
    $fatal(1, "trigger_stretcher: QUEUE_DEPTH must be >= 1");
  end

  trig_state_t      state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             dropped_n;
  logic             gap_last;
  logic             trig_busy;

`ifdef TRIGGER_STRETCHER_QUEUE_EN
  localparam int unsigned       PEND_W   = $clog2(QUEUE_DEPTH + 1);
  localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(QUEUE_DEPTH);
  logic [PEND_W-1:0] pending, pending_n;
`endif

  assign gap_last = (state == GAP) && (cnt == GAP_LAST);
  // A trigger that arrives while busy and cannot start a pulse right away.
  assign trig_busy = trig && ((state == HIGH) || ((state == GAP) && !gap_last));

  // Next-state, counter, queue and drop decision.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    dropped_n = 1'b0;
`ifdef TRIGGER_STRETCHER_QUEUE_EN
    pending_n = pending;
`endif
    unique case (state)
      IDLE: begin
        if (trig) begin
          state_n = HIGH;
          cnt_n   = '0;
        end
      end
      HIGH: begin
        if (cnt == PULSE_LAST) begin
          state_n = GAP;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      GAP: begin
        if (gap_last) begin
          cnt_n = '0;
`ifdef TRIGGER_STRETCHER_QUEUE_EN
          // Queued trigger wins; a coincident new trig takes its slot in the queue.
          if (pending != '0) begin
            state_n = HIGH;
            if (!trig) pending_n = pending - 1'b1;
          end else if (trig) begin
            state_n = HIGH;
          end else begin
            state_n = IDLE;
          end
`else
          state_n = trig ? HIGH : IDLE;
`endif
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase

    if (trig_busy) begin
`ifdef TRIGGER_STRETCHER_QUEUE_EN
      if (pending < PEND_MAX) pending_n = pending + 1'b1;
      else                    dropped_n = 1'b1;
`else
      dropped_n = 1'b1;
`endif
    end
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      out     <= 1'b0;
      busy    <= 1'b0;
      dropped <= 1'b0;
`ifdef TRIGGER_STRETCHER_QUEUE_EN
      pending <= '0;
`endif
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      out     <= (state_n == HIGH);
      busy    <= (state_n != IDLE);
      dropped <= dropped_n;
`ifdef TRIGGER_STRETCHER_QUEUE_EN
      pending <= pending_n;
`endif
    end
  end

endmodule
